// File: rtl/ext_pipe_unit.sv
// Sign/zero extender feeding a DEPTH-entry FIFO, with valid/ready handshakes on both sides.
// Optional pop counter output xfer_cnt is enabled by defining EXT_CNT_EN.
module ext_pipe_unit #(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_W-1:0]                in_data,
  input  logic [1:0]                     in_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_W-1:0]               out_data,
  output logic                           out_neg,
  output logic [$clog2(DEPTH+1)-1:0]     level
`ifdef EXT_CNT_EN
  ,
  output logic [15:0]                    xfer_cnt
`endif
);

  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [OUT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext_val;
  logic             push;
  logic             pop;

  // Extension happens on the push side so the FIFO stores final results.
  always_comb begin
    sext    = {{PAD_W{in_data[IN_W-1]}}, in_data};
    ext_val = '0;
    case (in_mode)
      2'b00:   ext_val = {{PAD_W{1'b0}}, in_data};
      2'b01:   ext_val = sext;
      2'b10:   ext_val = {in_data, {PAD_W{1'b0}}};
      default: ext_val = {sext[OUT_W-2:0], 1'b0};
    endcase
  end

  // Full/empty come from the registered level only; out_ready never gates in_ready.
  assign in_ready  = rst_n & (level_q != LVL_W'(DEPTH));
  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_neg   = out_valid & mem_q[rd_ptr_q][OUT_W-1];
  assign level     = level_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = ext_val;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

`ifdef EXT_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  // Saturating count of completed output handshakes.
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (pop && (xfer_cnt_q != 16'hFFFF)) xfer_cnt_d = xfer_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) xfer_cnt_q <= '0;
    else        xfer_cnt_q <= xfer_cnt_d;
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule
